alu_share_arbiter: RTL

Shares one combinational integer arithmetic unit between NUM_REQ requesters, e.g. the execute pipe and the branch/address-generation path. Round-robin arbitration accepts one operation per cycle into an issue register that drives the shared unit. The result is captured into a tagged response register, which returns it to the owning requester over valid/ready. Sits between the requesters and the arithmetic unit; the arithmetic unit itself stays outside the block.

---
 rtl/alu_arb_pkg.sv | 32 +++
 rtl/alu_share_arbiter_if.sv | 50 +++++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// ============================================================
// Module : alu_arb_pkg
// Desc   : Shared types and helpers for the ALU share arbiter.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

package alu_arb_pkg;

    localparam int MAX_REQ   = 4;
    localparam int ALU_XLEN  = 32;
    localparam int ALU_IMM_W = 12;

    // Wide enough for any legal requester count; blocks narrow it locally.
    typedef logic [$clog2(MAX_REQ)-1:0] tag_t;

    typedef struct packed {
        logic [ALU_XLEN-1:0]  op1;
        logic [ALU_XLEN-1:0]  op2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic                 imm_flag;
        logic [ALU_IMM_W-1:0] imm;
    } alu_req_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
// ============================================================
// Module : alu_share_arbiter_if
// Desc   : Requester, shared-unit and response bundle.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int IMM_W   = 12
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*XLEN-1:0]  req_op1;
    logic [NUM_REQ*XLEN-1:0]  req_op2;
    logic [NUM_REQ*3-1:0]     req_funct3;
    logic [NUM_REQ*7-1:0]     req_funct7;
    logic [NUM_REQ-1:0]       req_imm_flag;
    logic [NUM_REQ*IMM_W-1:0] req_imm;

    logic [XLEN-1:0]          alu_op1;
    logic [XLEN-1:0]          alu_op2;
    logic [2:0]               alu_funct3;
    logic [6:0]               alu_funct7;
    logic                     alu_imm_flag;
    logic [IMM_W-1:0]         alu_imm;
    logic [XLEN-1:0]          alu_result;

    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [XLEN-1:0]          rsp_result;

    modport slave (
        input  req_valid, req_op1, req_op2, req_funct3, req_funct7,
               req_imm_flag, req_imm, alu_result, rsp_ready,
        output req_ready, alu_op1, alu_op2, alu_funct3, alu_funct7,
               alu_imm_flag, alu_imm, rsp_valid, rsp_result
    );

    modport master (
        output req_valid, req_op1, req_op2, req_funct3, req_funct7,
               req_imm_flag, req_imm, alu_result, rsp_ready,
        input  req_ready, alu_op1, alu_op2, alu_funct3, alu_funct7,
               alu_imm_flag, alu_imm, rsp_valid, rsp_result
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================
// Module : rr_arbiter
// Desc   : Combinational round-robin grant starting at ptr.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   idx
);

    int               w_cand;
    logic [TAG_W-1:0] w_sel;
    logic             w_found;

    // Scan from ptr with wrap; the first asserted request wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_sel = TAG_W'(w_cand);
            if (en && !w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                idx          = w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================
// Module : alu_share_arbiter
// Desc   : Round-robin sharing of one external ALU, issue + tagged response regs.
// Rev    : 1.0 - initial release
// ============================================================
`default_nettype none

module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = ALU_XLEN,
    parameter int IMM_W   = ALU_IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    alu_share_arbiter_if.slave bus
);

    localparam int TAG_W = $clog2(NUM_REQ);

    alu_req_t           w_req [NUM_REQ];
    logic [NUM_REQ-1:0] w_grant;
    logic [TAG_W-1:0]   w_idx;
    logic               w_rsp_fire;
    logic               w_iss_adv;
    logic               w_iss_free;
    logic               w_arb_en;
    logic               w_req_fire;

    logic               r_iss_valid;
    logic [TAG_W-1:0]   r_iss_tag;
    alu_req_t           r_iss;
    logic               r_rsp_v;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [XLEN-1:0]    r_rsp_result;
    logic [TAG_W-1:0]   r_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req[gi] = '{
                op1:      bus.req_op1[gi*XLEN +: XLEN],
                op2:      bus.req_op2[gi*XLEN +: XLEN],
                funct3:   bus.req_funct3[gi*3 +: 3],
                funct7:   bus.req_funct7[gi*7 +: 7],
                imm_flag: bus.req_imm_flag[gi],
                imm:      bus.req_imm[gi*IMM_W +: IMM_W]
            };
        end
    endgenerate

    assign w_rsp_fire = r_rsp_v && bus.rsp_ready[r_rsp_tag];
    assign w_iss_adv  = r_iss_valid && (!r_rsp_v || w_rsp_fire);
    assign w_iss_free = !r_iss_valid || w_iss_adv;
    assign w_arb_en   = w_iss_free && !flush && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (r_ptr),
        .en    (w_arb_en),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign bus.req_ready = w_grant;
    assign w_req_fire    = |(bus.req_valid & w_grant);

    // A stalled response freezes the issue register too (head-of-line blocking).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_valid  <= 1'b0;
            r_iss_tag    <= '0;
            r_iss        <= '0;
            r_rsp_v      <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_result <= '0;
            r_ptr        <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
            r_rsp_v     <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_iss_valid <= 1'b1;
                r_iss_tag   <= w_idx;
                r_iss       <= w_req[w_idx];
                r_ptr       <= TAG_W'(rr_next(int'(w_idx), NUM_REQ));
            end else if (w_iss_adv) begin
                r_iss_valid <= 1'b0;
            end

            if (w_iss_adv) begin
                r_rsp_v      <= 1'b1;
                r_rsp_tag    <= r_iss_tag;
                r_rsp_result <= bus.alu_result;
            end else if (w_rsp_fire) begin
                r_rsp_v <= 1'b0;
            end
        end
    end

    generate
        for (genvar gr = 0; gr < NUM_REQ; gr++) begin : g_rsp_valid
            assign bus.rsp_valid[gr] = r_rsp_v && (r_rsp_tag == TAG_W'(gr));
        end
    endgenerate

    assign bus.rsp_result   = r_rsp_result;
    assign bus.alu_op1      = r_iss.op1;
    assign bus.alu_op2      = r_iss.op2;
    assign bus.alu_funct3   = r_iss.funct3;
    assign bus.alu_funct7   = r_iss.funct7;
    assign bus.alu_imm_flag = r_iss.imm_flag;
    assign bus.alu_imm      = r_iss.imm;

endmodule

`default_nettype wire
